ps2_host_ctrl: RTL and testbench
================================

PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 Parameter FILT_CYC, default 4, meaning cycles a synchronized PS/2 line must hold steady before the filtered value changes.
REQ-002 Parameter INHIBIT_CYC, default 1000, meaning clk cycles the PS/2 clock is held low before a host transmit (100 us at 10 MHz).
REQ-003 Parameter TIMEOUT_CYC, default 200000, meaning maximum clk cycles between PS/2 clock falling edges inside a frame.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ps2_clk_i / ps2_dat_i  in  1 each  raw PS/2 clock and data, asynchronous, idle high.
REQ-007 ps2_clk_oe / ps2_dat_oe  out  1 each  1 = pull line low (open-drain), 0 = release.
REQ-008 rx_valid  out  1  one-cycle pulse, rx_data valid; rx_data  out  8  received byte; rx_err  out  1  one-cycle pulse on bad frame.
REQ-009 tx_valid  in  1, tx_data  in  8, tx_ready  out  1  byte-to-device handshake; transfer when tx_valid && tx_ready.
REQ-010 tx_done  out  1  one-cycle pulse at end of transmit; tx_err  out  1  qualified by tx_done, 1 = no ACK or timeout.

Function
REQ-011 Each PS/2 input SHALL pass a 2-flop synchronizer then the FILT_CYC filter; a "fall event" is a 1->0 of filtered clock, one cycle wide.
REQ-012 States: IDLE, RX, INHIBIT, RTS, TX, TX_ACK, WAIT_IDLE.
REQ-013 Frame: start 0, 8 data LSB first, odd parity, stop 1; data sampled at fall events.
REQ-014 IDLE -> RX on a fall event with filtered data 0 (start bit); RX counts remaining 10 bits.
REQ-015 At the stop-bit fall event: odd parity over data+parity and stop=1 -> rx_valid pulse, rx_data updated; otherwise rx_err pulse, rx_data unchanged; then IDLE.
REQ-016 rx_data SHALL hold its last value until the next good frame; there is no backpressure.
REQ-017 tx_ready = 1 only in IDLE with no fall event in the same cycle; on transfer, latch tx_data and its odd parity, go to INHIBIT.
REQ-018 Arbitration: a fall event in IDLE always wins over tx_valid in the same cycle; the transmit waits and is accepted after RX completes.
REQ-019 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then RTS.
REQ-020 RTS (one cycle): ps2_dat_oe=1 (start bit), ps2_clk_oe=0, then TX.
REQ-021 TX: fall events 1..8 drive data bits 0..7, fall 9 drives parity, fall 10 releases data (stop), then TX_ACK; drive low means ps2_dat_oe=1.
REQ-022 TX_ACK: at next fall event, filtered data 0 = ACK; go to WAIT_IDLE with tx_err latched = !ACK.
REQ-023 WAIT_IDLE: when both filtered lines are 1, pulse tx_done (with latched tx_err) and go to IDLE.
REQ-024 Timeout counter SHALL reset on every fall event and state entry; in RX, TX, TX_ACK or WAIT_IDLE reaching TIMEOUT_CYC -> release both lines, IDLE; from RX pulse rx_err, otherwise pulse tx_done with tx_err=1.
REQ-025 Outside INHIBIT/RTS/TX, ps2_clk_oe and ps2_dat_oe SHALL be 0.

Reset
REQ-026 On rst_n low, asynchronously: state IDLE, both *_oe = 0, rx_valid/rx_err/tx_done/tx_err = 0, rx_data = 0, counters and filters cleared to idle-high.
REQ-027 Reset mid-frame SHALL abandon the frame with no rx/tx pulse; tx_ready = 1 from the first cycle after release if lines are idle.

Structure
REQ-028 Shared package ps2_pkg: state enum, frame bit-count constants, odd-parity function.
REQ-029 Sub-module ps2_line_filter (synchronizer + FILT_CYC deglitch + fall-event output), instantiated for clock and data.

Verification
REQ-030 Device sends 0x5A, parity 1, stop 1 -> one rx_valid pulse, rx_data = 0x5A, no rx_err.
REQ-031 Device sends 0x3C with parity bit flipped -> rx_err pulse, rx_data unchanged, no rx_valid.
REQ-032 tx 0xED, device model clocks and ACKs -> clock low exactly INHIBIT_CYC cycles, bits 1,0,1,1,0,1,1,1 then parity 1, tx_done with tx_err = 0.
REQ-033 tx 0xF4, device gives no ACK -> tx_done with tx_err = 1, both lines released.
REQ-034 tx_valid asserted in the same cycle as a device start-bit fall event -> RX of 0xAA completes first, tx accepted next IDLE cycle.
REQ-035 Device stops after 4 data bits -> rx_err after TIMEOUT_CYC cycles, IDLE; reset asserted during TX -> both *_oe = 0 immediately, no tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame constants and parity helper for the PS/2 host
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, RX, INHIBIT, RTS, TX, TX_ACK, WAIT_IDLE} state_t;
  localparam int RX_BITS = 10;
  localparam int TX_BITS = 10;
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer, FILT_CYC deglitch and one-cycle fall-event output
module ps2_line_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic fall
);
  localparam int CW = $clog2(FILT_CYC + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      fall <= 1'b0;
      if (sync[1] == filt) cnt <= '0;
      else if (cnt == CW'(FILT_CYC - 1)) begin
        cnt  <= '0;
        filt <= sync[1];
        fall <= filt;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host controller -- receives device frames and transmits host bytes
module ps2_host_ctrl import ps2_pkg::*; #(
  parameter int FILT_CYC    = 4,
  parameter int INHIBIT_CYC = 1000,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int TMAX = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(TMAX + 1);
  state_t state, nxt;
  logic clk_f, clk_fall, dat_f, dat_fall;
  logic [CW-1:0] cnt;
  logic [3:0] bit_cnt;
  logic [8:0] rx_sh;
  logic [9:0] tx_sh;
  logic dat_drv, err_q, tmo, line_idle;
  logic rx_ok, rx_bad, done, done_err;
  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_clk (.clk(clk), .rst_n(rst_n), .raw(ps2_clk_i), .filt(clk_f), .fall(clk_fall));
  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_dat (.clk(clk), .rst_n(rst_n), .raw(ps2_dat_i), .filt(dat_f), .fall(dat_fall));
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
  assign line_idle = clk_f & dat_f & ~dat_fall;
  assign ps2_clk_oe = state == INHIBIT;
  assign ps2_dat_oe = state == RTS | (state == TX & dat_drv);
  always_comb begin
    nxt      = state;
    rx_ok    = 1'b0;
    rx_bad   = 1'b0;
    done     = 1'b0;
    done_err = 1'b0;
    tx_ready = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = ~clk_fall;
        nxt = (clk_fall & ~dat_f) ? RX : (tx_valid & ~clk_fall) ? INHIBIT : IDLE;
      end
      RX:
        if (clk_fall & bit_cnt == 4'(RX_BITS - 1)) begin
          nxt    = IDLE;
          rx_ok  = dat_f & ^rx_sh;
          rx_bad = ~(dat_f & ^rx_sh);
        end else if (tmo) begin
          nxt    = IDLE;
          rx_bad = 1'b1;
        end
      INHIBIT: nxt = (cnt == CW'(INHIBIT_CYC - 1)) ? RTS : INHIBIT;
      RTS:     nxt = TX;
      TX, TX_ACK, WAIT_IDLE:
        if (state == TX & clk_fall & bit_cnt == 4'(TX_BITS - 1)) nxt = TX_ACK;
        else if (state == TX_ACK & clk_fall) nxt = WAIT_IDLE;
        else if (state == WAIT_IDLE & line_idle) begin
          nxt      = IDLE;
          done     = 1'b1;
          done_err = err_q;
        end else if (tmo) begin
          nxt      = IDLE;
          done     = 1'b1;
          done_err = 1'b1;
        end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_sh    <= '1;
      dat_drv  <= 1'b0;
      err_q    <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= '0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      state    <= nxt;
      // the inhibit window is timed from entry only; our own clock pull-down must not restart it
      cnt      <= (nxt != state | (clk_fall & state != INHIBIT)) ? '0 : cnt + 1'b1;
      bit_cnt  <= (nxt != state) ? '0 : clk_fall ? bit_cnt + 1'b1 : bit_cnt;
      rx_valid <= rx_ok;
      rx_err   <= rx_bad;
      tx_done  <= done;
      tx_err   <= done_err;
      if (rx_ok) rx_data <= rx_sh[7:0];
      if (state == RX & clk_fall) rx_sh <= {dat_f, rx_sh[8:1]};
      if (state == IDLE & nxt == INHIBIT) tx_sh <= {1'b1, odd_par(tx_data), tx_data};
      if (state == RTS) dat_drv <= 1'b1;
      else if (state == TX & clk_fall) begin
        dat_drv <= ~tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[9:1]};
      end
      if (state == TX_ACK & clk_fall) err_q <= dat_f;
    end
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: directed PS/2 device model with rx/tx scoreboards
module tb_ps2_host_ctrl;
  localparam int FC = 4, INH = 50, TO = 2000, H = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic dev_clk = 1'b1, dev_dat = 1'b1;
  logic ps2_clk_i, ps2_dat_i, ps2_clk_oe, ps2_dat_oe;
  logic rx_valid, rx_err, tx_valid = 1'b0, tx_ready, tx_done, tx_err;
  logic [7:0] rx_data, tx_data = 8'h00;
  int tests = 0, fails = 0, cyc = 0, rx_seen = 0, tx_seen = 0, rx_evt_cyc = 0, last_fall = 0;
  logic [9:0] exp_rx[$];
  logic exp_tx[$];
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ps2_host_ctrl #(.FILT_CYC(FC), .INHIBIT_CYC(INH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_err(rx_err), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (rx_valid | rx_err) begin
      rx_seen++;
      rx_evt_cyc = cyc;
      if (exp_rx.size() == 0) chk("rx_unexpected", {22'd0, rx_err, rx_valid, rx_data}, 32'hdead);
      else chk("rx_event", {22'd0, rx_err, rx_valid, rx_data}, {22'd0, exp_rx.pop_front()});
    end
    if (tx_done) begin
      tx_seen++;
      if (exp_tx.size() == 0) chk("tx_unexpected", {31'd0, tx_err}, 32'hdead);
      else chk("tx_err", {31'd0, tx_err}, {31'd0, exp_tx.pop_front()});
    end
  end

  task automatic dev_send(input logic [7:0] d, input logic par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = fr[i];
      repeat (H) @(posedge clk);
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (H) @(posedge clk);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  task automatic dev_recv(input logic ack, output logic [9:0] bits, output int inh);
    for (int i = 0; i < 500 && !ps2_clk_oe; i++) @(negedge clk);
    inh = 0;
    while (ps2_clk_oe && inh < 5000) begin
      inh++;
      @(negedge clk);
    end
    repeat (H) @(negedge clk);
    chk("start_bit", {31'd0, ps2_dat_i}, 0);
    for (int i = 0; i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      bits[i] = ps2_dat_i;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_dat = ~ack;
    repeat (H) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] d);
    int i;
    tx_data = d;
    tx_valid = 1'b1;
    for (i = 0; i < 3000 && !tx_ready; i++) @(negedge clk);
    if (i == 3000) chk("tx_accept_wait", 0, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_cnt(input string tag, input int which, input int n);
    int i;
    for (i = 0; i < 6000 && (which == 0 ? rx_seen : tx_seen) < n; i++) @(negedge clk);
    chk(tag, {31'd0, i < 6000}, 1);
  endtask

  initial begin
    logic [9:0] bits;
    int inh, snap, el, i;
    repeat (3) @(negedge clk);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("rst_outs", {28'd0, rx_valid, rx_err, tx_done, tx_err}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_ready", {31'd0, tx_ready}, 1);
    // good frame 0x5A
    exp_rx.push_back({1'b0, 1'b1, 8'h5A});
    dev_send(8'h5A, 1'b1, 11);
    wait_cnt("rx_5a_wait", 0, 1);
    // 0x3C with wrong parity: error, data held
    exp_rx.push_back({1'b1, 1'b0, 8'h5A});
    dev_send(8'h3C, 1'b0, 11);
    wait_cnt("rx_3c_wait", 0, 2);
    chk("rx_data_hold", {24'd0, rx_data}, 32'h5A);
    // host transmit 0xED with ACK
    exp_tx.push_back(1'b0);
    fork
      send_tx(8'hED);
      dev_recv(1'b1, bits, inh);
    join
    chk("inhibit_len", inh, INH);
    chk("tx_ed_data", {24'd0, bits[7:0]}, 32'hED);
    chk("tx_ed_par", {31'd0, bits[8]}, 1);
    chk("tx_ed_stop", {31'd0, bits[9]}, 1);
    wait_cnt("tx_ed_wait", 1, 1);
    // host transmit 0xF4 without ACK
    exp_tx.push_back(1'b1);
    fork
      send_tx(8'hF4);
      dev_recv(1'b0, bits, inh);
    join
    chk("tx_f4_data", {24'd0, bits[7:0]}, 32'hF4);
    chk("tx_f4_par", {31'd0, bits[8]}, 0);
    wait_cnt("tx_f4_wait", 1, 2);
    @(negedge clk);
    chk("tx_f4_release", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    // tx_valid collides with start-bit fall: RX 0xAA first
    exp_rx.push_back({1'b0, 1'b1, 8'hAA});
    fork
      dev_send(8'hAA, 1'b1, 11);
      begin
        for (i = 0; i < 200 && tx_ready; i++) @(negedge clk);
        chk("arb_fall_seen", {31'd0, tx_ready}, 0);
        tx_data = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        for (i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
        chk("arb_next_idle", {31'd0, rx_valid}, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        chk("arb_rx_first", rx_seen, 3);
      end
    join
    exp_tx.push_back(1'b0);
    dev_recv(1'b1, bits, inh);
    chk("arb_tx_data", {24'd0, bits[7:0]}, 32'h12);
    wait_cnt("arb_tx_wait", 1, 3);
    // device stalls after 4 data bits
    exp_rx.push_back({1'b1, 1'b0, 8'hAA});
    dev_send(8'h55, 1'b1, 5);
    wait_cnt("tmo_wait", 0, 4);
    el = rx_evt_cyc - last_fall;
    chk("tmo_min", {31'd0, el >= TO}, 1);
    chk("tmo_max", {31'd0, el <= TO + 20}, 1);
    chk("tmo_idle", {31'd0, tx_ready}, 1);
    // reset while driving a data bit in TX
    snap = tx_seen;
    send_tx(8'h00);
    for (i = 0; i < 500 && !ps2_clk_oe; i++) @(negedge clk);
    for (i = 0; i < 500 && ps2_clk_oe; i++) @(negedge clk);
    repeat (H) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    chk("tx_driving", {31'd0, ps2_dat_oe}, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 1);
    repeat (300) @(negedge clk);
    chk("rst_no_done", tx_seen, snap);
    chk("rx_q_empty", exp_rx.size(), 0);
    chk("tx_q_empty", exp_tx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
